// File: rtl/host_mem_ctl_if.sv
// rtl/host_mem_ctl_if.sv - host register bus and logic-side memory bus for host_mem_ctl
interface host_mem_ctl_if;
    logic [1:0]  i_reg_ctl;
    logic [31:0] i_reg_addr;
    logic [31:0] i_reg_data;
    logic [31:0] o_reg_data;
    logic        i_read_en;
    logic [63:0] i_read_addr;
    logic        i_write_en;
    logic [63:0] i_write_addr;
    logic [63:0] i_data;
    logic [63:0] o_data;

    modport master (
        output i_reg_ctl, i_reg_addr, i_reg_data,
        output i_read_en, i_read_addr, i_write_en, i_write_addr, i_data,
        input  o_reg_data, o_data
    );

    modport slave (
        input  i_reg_ctl, i_reg_addr, i_reg_data,
        input  i_read_en, i_read_addr, i_write_en, i_write_addr, i_data,
        output o_reg_data, o_data
    );
endinterface

// File: rtl/host_mem_ctl.sv
// rtl/host_mem_ctl.sv - local 64-bit RAM shared between host registers and the logic core, with run control
module host_mem_ctl #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_halted,
    output logic         o_logic_en,
    host_mem_ctl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

    state_t            state, next_state;
    logic              logic_en_d;
    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       stage_lo;
    logic [31:0]       cycles;
    logic              err, oob;
    logic [31:0]       reg_rdata;

    logic host_rd, host_wr, run, ctrl_wr, clear_sticky;
    logic ram_access, host_commit, host_rd_hi;
    logic rd_oob, wr_oob, lg_rd, lg_wr, lg_wr_ok;

    assign host_rd      = (bus.i_reg_ctl == 2'd1);
    assign host_wr      = (bus.i_reg_ctl == 2'd2);
    assign run          = (state == RUN);
    assign ctrl_wr      = host_wr && (bus.i_reg_addr == 32'd0);
    assign clear_sticky = ctrl_wr && bus.i_reg_data[1];

    // The host may only touch RAM while the core is not running
    assign ram_access  = (host_rd && (bus.i_reg_addr == 32'd2)) ||
                         ((host_rd || host_wr) && (bus.i_reg_addr == 32'd3));
    assign host_commit = host_wr && (bus.i_reg_addr == 32'd3) && !run;
    assign host_rd_hi  = host_rd && (bus.i_reg_addr == 32'd3) && !run;

    assign rd_oob   = (bus.i_read_addr >= 64'(DEPTH));
    assign wr_oob   = (bus.i_write_addr >= 64'(DEPTH));
    assign lg_rd    = run && bus.i_read_en;
    assign lg_wr    = run && bus.i_write_en;
    assign lg_wr_ok = lg_wr && !wr_oob;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            o_logic_en <= 1'b0;
        end else begin
            state      <= next_state;
            o_logic_en <= logic_en_d;
        end
    end

    // A stop write takes priority over a halt seen in the same cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ctrl_wr && bus.i_reg_data[0]) next_state = RUN;
            RUN:     if (ctrl_wr && !bus.i_reg_data[0]) next_state = IDLE;
                     else if (i_halted) next_state = HALTED;
            HALTED:  if (ctrl_wr && !bus.i_reg_data[0]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        logic_en_d = (next_state == RUN);
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (bus.i_reg_addr)
            32'd0: reg_rdata = {27'd0, oob, err, i_halted, state};
            32'd1: reg_rdata = {{(32-ADDR_W){1'b0}}, ptr};
            32'd2: reg_rdata = run ? 32'd0 : mem[ptr][31:0];
            32'd3: reg_rdata = run ? 32'd0 : mem[ptr][63:32];
            32'd4: reg_rdata = cycles;
            default: reg_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bus.o_reg_data <= 32'd0;
            bus.o_data     <= 64'd0;
            ptr            <= '0;
            stage_lo       <= 32'd0;
            cycles         <= 32'd0;
            err            <= 1'b0;
            oob            <= 1'b0;
        end else begin
            if (host_rd)
                bus.o_reg_data <= reg_rdata;

            if (host_wr && (bus.i_reg_addr == 32'd1))
                ptr <= bus.i_reg_data[ADDR_W-1:0];
            else if (host_commit || host_rd_hi)
                ptr <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;

            if (host_wr && (bus.i_reg_addr == 32'd2))
                stage_lo <= bus.i_reg_data;

            if (clear_sticky)
                cycles <= 32'd0;
            else if (o_logic_en && (cycles != 32'hFFFF_FFFF))
                cycles <= cycles + 32'd1;

            if (clear_sticky)
                err <= 1'b0;
            else if (ram_access && run)
                err <= 1'b1;

            if (clear_sticky)
                oob <= 1'b0;
            if ((lg_rd && rd_oob) || (lg_wr && wr_oob))
                oob <= 1'b1;

            if (lg_rd)
                bus.o_data <= rd_oob ? 64'd0 : mem[bus.i_read_addr[ADDR_W-1:0]];
        end
    end

    // RAM has no reset so its contents survive a mid-run reset
    always_ff @(posedge i_clk) begin
        if (host_commit)
            mem[ptr] <= {bus.i_reg_data, stage_lo};
        else if (lg_wr_ok)
            mem[bus.i_write_addr[ADDR_W-1:0]] <= bus.i_data;
    end
endmodule
